// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_pkg : shared FSM state type and constants for uart_tx_arbiter |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package uart_pkg;

  localparam int C_BYTE_W               = 8;
  localparam int C_DEFAULT_BUSY_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } uart_arb_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick, search after winner   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_winner,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] winner,
  output logic             any_grant
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Walk offsets 1..N from the previous winner; first requesting index wins.
  always_comb begin
    grant     = '0;
    winner    = last_winner;
    any_grant = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      sum = {1'b0, last_winner} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(N_REQ)) begin
        sum = sum - (IDX_W+1)'(N_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!any_grant && req[cand]) begin
        any_grant   = 1'b1;
        grant[cand] = 1'b1;
        winner      = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx_arbiter : round-robin share of one UART TX among N_REQ     |
// | requesters. Optional packet locking via UART_ARB_LOCK_EN.          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = C_DEFAULT_BUSY_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [C_BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic [C_BYTE_W-1:0]       uart_w_data,
  output logic                      uart_valid,
  input  logic                      uart_busy,
  output logic [N_REQ-1:0]          out_grant,
  output logic                      out_err_timeout
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(BUSY_TIMEOUT);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] C_LW_RST   = IDX_W'(N_REQ - 1);

  uart_arb_state_e       state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [C_BYTE_W-1:0]   data_q, data_d;
  logic                  valid_q, valid_d;
  logic [N_REQ-1:0]      ready_q, ready_d;
  logic [N_REQ-1:0]      grant_q, grant_d;
  logic                  err_q, err_d;
  logic [IDX_W-1:0]      last_winner_q, last_winner_d;
  logic                  lock_q, lock_d;

  logic [N_REQ-1:0]      arb_req;
  logic [N_REQ-1:0]      arb_grant;
  logic [IDX_W-1:0]      arb_winner;
  logic                  arb_any;
  logic [C_BYTE_W-1:0]   win_data;
  logic                  acc_last;

  // While a packet is locked only the owner may be picked.
  assign arb_req = lock_q ? (req_valid & grant_q) : req_valid;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req         (arb_req),
    .last_winner (last_winner_q),
    .grant       (arb_grant),
    .winner      (arb_winner),
    .any_grant   (arb_any)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) begin
        win_data = win_data | req_data[i*C_BYTE_W +: C_BYTE_W];
      end
    end
  end

`ifdef UART_ARB_LOCK_EN
  always_comb begin
    acc_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) begin
        acc_last = acc_last | req_last[i];
      end
    end
  end
`else
  // Every byte is its own packet, so the lock never engages.
  logic unused_last;
  assign unused_last = ^req_last;
  assign acc_last    = 1'b1;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    data_d        = data_q;
    grant_d       = grant_q;
    last_winner_d = last_winner_q;
    lock_d        = lock_q;
    ready_d       = '0;
    err_d         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!uart_busy && arb_any) begin
          state_d       = ST_ISSUE;
          cnt_d         = '0;
          data_d        = win_data;
          grant_d       = arb_grant;
          ready_d       = arb_grant;
          last_winner_d = arb_winner;
          lock_d        = ~acc_last;
        end
      end
      ST_ISSUE: begin
        if (uart_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q >= C_CNT_LAST) begin
          // Final ISSUE cycle without busy: the pulse lands BUSY_TIMEOUT cycles after entry.
          state_d = ST_IDLE;
          cnt_d   = C_CNT_MAX;
          err_d   = 1'b1;
          grant_d = '0;
          lock_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!uart_busy) begin
          state_d = ST_IDLE;
          if (!lock_q) begin
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        lock_d  = 1'b0;
      end
    endcase
    valid_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      ready_q       <= '0;
      grant_q       <= '0;
      err_q         <= 1'b0;
      last_winner_q <= C_LW_RST;
      lock_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      ready_q       <= ready_d;
      grant_q       <= grant_d;
      err_q         <= err_d;
      last_winner_q <= last_winner_d;
      lock_q        <= lock_d;
    end
  end

  assign req_ready       = ready_q;
  assign uart_w_data     = data_q;
  assign uart_valid      = valid_q;
  assign out_grant       = grant_q;
  assign out_err_timeout = err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_uart_tx_arbiter : scoreboard bench with queue-based requesters  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int T = 16;
`ifdef UART_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_last, req_ready, out_grant;
  logic [8*N-1:0] req_data;
  logic [7:0]     uart_w_data;
  logic           uart_valid, uart_busy, out_err_timeout;

  uart_tx_arbiter #(.N_REQ(N), .BUSY_TIMEOUT(T)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .uart_w_data     (uart_w_data),
    .uart_valid      (uart_valid),
    .uart_busy       (uart_busy),
    .out_grant       (out_grant),
    .out_err_timeout (out_err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] data; logic last; } item_t;
  typedef struct packed { logic [7:0] data; logic [N-1:0] grant; } exp_t;

  item_t      rq [N][$];
  exp_t       exp_q[$];
  logic [7:0] obs_q[$];

  int checks = 0, errors = 0;
  int err_seen = 0, exp_errs = 0;
  int cyc = 0;
  bit mute = 0;
  int fixed_dly = 0, fixed_hold = 0;
  int m_lw;
  bit m_lock;
  int m_owner;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = rq[i][0].data;
        req_last[i]        = rq[i][0].last;
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    end
    drive_reqs();
  endtask

  // Reference: whole queues are present at once, so the service order follows
  // directly from round-robin over the non-empty queues plus packet locking.
  task automatic model_schedule();
    item_t      cq [N][$];
    item_t      it;
    exp_t       e;
    int         w, c;
    for (int i = 0; i < N; i++) cq[i] = rq[i];
    while (1) begin
      w = -1;
      if (m_lock) begin
        if (cq[m_owner].size() > 0) w = m_owner;
      end else begin
        for (int k = 1; k <= N; k++) begin
          c = (m_lw + k) % N;
          if (w < 0 && cq[c].size() > 0) w = c;
        end
      end
      if (w < 0) break;
      it      = cq[w].pop_front();
      e.data  = it.data;
      e.grant = '0;
      e.grant[w] = 1'b1;
      exp_q.push_back(e);
      m_lw    = w;
      m_owner = w;
      m_lock  = LOCK && !it.last;
    end
  endtask

  task automatic load(input int r, input logic [7:0] d, input logic l);
    item_t it;
    it.data = d;
    it.last = l;
    rq[r].push_back(it);
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      step();
      if (all_empty() && exp_q.size() == 0 && !uart_valid && !uart_busy) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: idle not reached, got pending=%0d expected 0", name, exp_q.size());
    end
    repeat (2) step();
  endtask

  task automatic check_obs(input string name, input logic [7:0] ref_q[$]);
    for (int i = 0; i < ref_q.size(); i++) begin
      if (i < obs_q.size()) chk(name, obs_q[i], ref_q[i]);
      else chk(name, 32'hdead_beef, ref_q[i]);
    end
  endtask

  // Monitor: pops the scoreboard at each new UART transfer.
  initial begin : monitor
    bit   prev_v = 1'b0;
    int   issue_cyc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (uart_valid && !prev_v) begin
          issue_cyc = cyc;
          obs_q.push_back(uart_w_data);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_transfer: got data 0x%0h expected none", uart_w_data);
          end else begin
            e = exp_q.pop_front();
            chk("uart_data", uart_w_data, e.data);
            chk("grant", out_grant, e.grant);
            chk("req_ready", req_ready, e.grant);
          end
        end else begin
          chk("ready_outside_accept", req_ready, 0);
        end
        if (out_err_timeout) begin
          err_seen++;
          chk("timeout_latency", cyc - issue_cyc, T);
          chk("timeout_valid", uart_valid, 0);
          chk("timeout_grant", out_grant, 0);
        end
        prev_v = uart_valid;
      end
    end
  end

  // UART transmitter model: busy rises some cycles after a request, then holds.
  initial begin : uart_model
    int dly, hold;
    uart_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_valid && !uart_busy && !mute) begin
        dly = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 3));
        repeat (dly) @(negedge clk);
        uart_busy = 1'b1;
        hold = (fixed_hold > 0) ? fixed_hold : int'($urandom_range(1, 5));
        repeat (hold) @(negedge clk);
        uart_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] ref_q[$];
    int len;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    m_lw      = N - 1;
    m_lock    = 1'b0;
    m_owner   = 0;
    repeat (3) @(negedge clk);
    chk("rst_uart_valid", uart_valid, 0);
    chk("rst_uart_data", uart_w_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_grant", out_grant, 0);
    chk("rst_err", out_err_timeout, 0);
    rst_n = 1'b1;
    step();

    // All four requesters continuously valid.
    obs_q.delete();
    for (int r = 0; r < N; r++) begin
      load(r, 8'h10 + 8'(r), 1'b1);
      load(r, 8'h10 + 8'(r), 1'b1);
    end
    model_schedule();
    drive_reqs();
    wait_idle("rr_phase");
    ref_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    check_obs("rr_order", ref_q);

    // Single byte, busy two cycles after issue.
    fixed_dly = 2;
    load(0, 8'h41, 1'b1);
    model_schedule();
    drive_reqs();
    step();
    chk("lat_req_ready", req_ready, 4'b0001);
    chk("lat_uart_valid", uart_valid, 1);
    chk("lat_uart_data", uart_w_data, 8'h41);
    step();
    step();
    chk("valid_before_busy_seen", uart_valid, 1);
    step();
    chk("valid_after_busy_seen", uart_valid, 0);
    wait_idle("single_phase");
    fixed_dly = 0;

    // Packet from requester 1 against a waiting requester 0.
    obs_q.delete();
    load(1, 8'hA0, 1'b0);
    load(1, 8'hA1, 1'b0);
    load(1, 8'hA2, 1'b1);
    load(0, 8'h55, 1'b1);
    model_schedule();
    drive_reqs();
    wait_idle("lock_phase");
    if (LOCK) ref_q = '{8'hA0, 8'hA1, 8'hA2, 8'h55};
    else      ref_q = '{8'hA0, 8'h55, 8'hA1, 8'hA2};
    check_obs("packet_order", ref_q);

    // Transmitter never responds.
    mute = 1'b1;
    load(2, 8'h5A, 1'b1);
    model_schedule();
    exp_errs++;
    drive_reqs();
    wait_idle("timeout_phase");
    chk("timeout_count", err_seen, exp_errs);
    mute = 1'b0;

    // Randomized traffic.
    for (int round = 0; round < 8; round++) begin
      for (int r = 0; r < N; r++) begin
        len = int'($urandom_range(0, 4));
        for (int k = 0; k < len; k++) begin
          load(r, 8'($urandom), (k == len - 1) ? 1'b1 : 1'($urandom_range(0, 1)));
        end
      end
      model_schedule();
      drive_reqs();
      wait_idle("random_phase");
    end

    // Reset while the transmitter is busy.
    fixed_hold = 10;
    load(2, 8'h77, 1'b1);
    model_schedule();
    drive_reqs();
    for (int n = 0; n < 100 && !uart_busy; n++) step();
    step();
    chk("pre_reset_grant", out_grant, 4'b0100);
    chk("pre_reset_data", uart_w_data, 8'h77);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", uart_valid, 0);
    chk("async_rst_data", uart_w_data, 0);
    chk("async_rst_ready", req_ready, 0);
    chk("async_rst_grant", out_grant, 0);
    chk("async_rst_err", out_err_timeout, 0);
    step();
    step();
    #2 rst_n = 1'b1;
    fixed_hold = 0;
    m_lw   = N - 1;
    m_lock = 1'b0;
    wait_idle("reset_recover");
    obs_q.delete();
    load(3, 8'h33, 1'b1);
    load(2, 8'h32, 1'b1);
    load(0, 8'h30, 1'b1);
    model_schedule();
    drive_reqs();
    wait_idle("post_reset_phase");
    ref_q = '{8'h30, 8'h32, 8'h33};
    check_obs("post_reset_order", ref_q);
    chk("final_timeout_count", err_seen, exp_errs);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter BUSY_TIMEOUT, default 16: cycles allowed for uart_busy to rise after issue.
REQ-003 clk  input  1  single clock, all logic on posedge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  N_REQ  per-requester byte-available flag.
REQ-006 req_data  input  8*N_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 req_last  input  N_REQ  per-requester end-of-packet flag, sampled with the byte.
REQ-008 req_ready  output  N_REQ  one-cycle pulse: byte of requester i accepted.
REQ-009 uart_w_data  output  8  byte to UART transmitter.
REQ-010 uart_valid  output  1  transfer request to UART transmitter.
REQ-011 uart_busy  input  1  UART transmitter busy flag.
REQ-012 out_grant  output  N_REQ  one-hot current owner; all-zero when idle.
REQ-013 out_err_timeout  output  1  one-cycle pulse: uart_busy did not rise within BUSY_TIMEOUT.

Function
REQ-014 FSM states: IDLE, ISSUE, WAIT_DONE; any other encoding returns to IDLE.
REQ-015 IDLE: when uart_busy=0 and any arbitrable req_valid=1, latch winner's data/last, pulse req_ready[winner], set out_grant, go ISSUE next cycle.
REQ-016 Latency: req_valid high at cycle 0 in IDLE with uart_busy=0 -> req_ready pulse and uart_valid high at cycle 1.
REQ-017 Arbitration round-robin: search starts at (last_winner+1) mod N_REQ, wraps; last_winner updates on each acceptance.
REQ-018 IDLE with uart_busy=1: no acceptance, no req_ready, wait.
REQ-019 ISSUE: uart_valid=1, uart_w_data=latched byte; on uart_busy=1 drop uart_valid next cycle, go WAIT_DONE.
REQ-020 ISSUE timeout: counter starts at 0 on entry; on reaching BUSY_TIMEOUT without uart_busy, pulse out_err_timeout, drop uart_valid, clear out_grant, go IDLE; byte is discarded.
REQ-021 WAIT_DONE: on uart_busy=0 go IDLE; out_grant cleared on that transition unless lock held (REQ-028).
REQ-022 Latched byte is immutable after acceptance; req_valid/req_data changes during ISSUE/WAIT_DONE are ignored.
REQ-023 At most one req_ready bit high per cycle; req_ready never high outside the IDLE->ISSUE transition.
REQ-024 Timeout counter width: $clog2(BUSY_TIMEOUT+1) bits, saturating, never wraps.

Reset
REQ-025 rst_n low, asynchronously: state IDLE, uart_valid=0, uart_w_data=0, req_ready=0, out_grant=0, out_err_timeout=0, counter=0, last_winner=N_REQ-1 (requester 0 wins first).
REQ-026 Reset mid-transfer abandons latched byte; no req_ready or error pulse on release.

Configuration
REQ-027 Macro UART_ARB_LOCK_EN compiles in packet locking.
REQ-028 With UART_ARB_LOCK_EN: after accepting a byte with req_last=0, grant stays with that requester; only its req_valid is arbitrable until a byte with req_last=1 completes WAIT_DONE or a timeout occurs.
REQ-029 Without UART_ARB_LOCK_EN: req_last ignored; re-arbitration after every byte.

Structure
REQ-030 Shared package uart_pkg: FSM state typedef (IDLE/ISSUE/WAIT_DONE), byte width constant 8, default BUSY_TIMEOUT constant.
REQ-031 Sub-module rr_arbiter (request vector, last_winner -> one-hot grant, combinational) instantiated once.

Verification
REQ-032 Req0 valid, data 0x41, uart_busy rises 2 cycles after issue -> req_ready[0] at cycle 1, uart_w_data=0x41, uart_valid drops after busy seen.
REQ-033 Req0..3 valid continuously, data 0x10..0x13 -> UART bytes in order 0x10,0x11,0x12,0x13,0x10.
REQ-034 uart_busy held 0 after issue -> out_err_timeout pulse exactly BUSY_TIMEOUT cycles after ISSUE entry, FSM IDLE next.
REQ-035 With UART_ARB_LOCK_EN: req1 sends 0xA0,0xA1(last=0),0xA2(last=1) while req0 valid -> 0xA0,0xA1,0xA2 precede req0's byte; without macro, bytes interleave.
REQ-036 rst_n pulsed low during WAIT_DONE -> all outputs 0 immediately; after release requester 0 wins first.
